// File: rtl/adder_share_arb_pkg.sv
// Shared constants and types for the shared-adder arbiter.
package adder_share_arb_pkg;

    localparam int unsigned ADD_LAT_DEF = 4;
    localparam int unsigned SLICE_W     = 8;
    localparam int unsigned MAX_IDW     = 3;
    localparam int unsigned CNT_W       = 16;

    // Tag carried alongside each issue; id is sized for the largest requester count.
    typedef struct packed {
        logic               vld;
        logic [MAX_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/adder_share_arb_rr_arb.sv
// Round-robin arbiter: one-hot grant searching upward from the pointer, pointer
// advances past the winner on acceptance.
module adder_share_arb_rr_arb
    import adder_share_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic            I_clk,
    input  logic            I_rst,
    input  logic            I_en,
    input  logic [NREQ-1:0] I_req,
    input  logic            I_acc,
    output logic [NREQ-1:0] O_gnt_c,
    output logic [IDW-1:0]  O_gnt_id_c
);

    logic [IDW-1:0] ptr_q;
    logic [IDW:0]   idx_c;
    logic           found_c;

    always_comb begin
        O_gnt_c    = '0;
        O_gnt_id_c = '0;
        found_c    = 1'b0;
        idx_c      = '0;
        if (I_en) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                idx_c = {1'b0, ptr_q} + (IDW+1)'(i);
                if (idx_c >= (IDW+1)'(NREQ)) begin
                    idx_c = idx_c - (IDW+1)'(NREQ);
                end
                if (!found_c && I_req[IDW'(idx_c)]) begin
                    found_c              = 1'b1;
                    O_gnt_c[IDW'(idx_c)] = 1'b1;
                    O_gnt_id_c           = IDW'(idx_c);
                end
            end
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            ptr_q <= '0;
        end else if (I_acc) begin
            ptr_q <= (O_gnt_id_c == IDW'(NREQ-1)) ? '0 : O_gnt_id_c + IDW'(1);
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Shares one fixed-latency pipelined adder among NREQ requesters and returns
// each sum tagged with the issuing requester's id.
module adder_share_arb
    import adder_share_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 24,
    parameter int unsigned ADD_LAT = ADD_LAT_DEF,
    parameter int unsigned IDW     = 2
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_en,
    input  logic [NREQ-1:0]    I_req_vld,
    input  logic [NREQ*DW-1:0] I_req_a,
    input  logic [NREQ*DW-1:0] I_req_b,
    output logic [NREQ-1:0]    O_req_rdy,
    output logic [DW-1:0]      O_add_a,
    output logic [DW-1:0]      O_add_b,
    output logic               O_add_vld,
    input  logic [DW-1:0]      I_sum,
    output logic               O_res_vld,
    output logic [IDW-1:0]     O_res_id,
    output logic [DW-1:0]      O_res_sum,
    output logic               O_busy,
    output logic [CNT_W-1:0]   O_issue_cnt
);

    logic [NREQ-1:0] gnt_c;
    logic [IDW-1:0]  gnt_id_c;
    logic            acc_c;
    logic [DW-1:0]   a_sel_c;
    logic [DW-1:0]   b_sel_c;
    logic            tag_any_c;
    tag_t            tag_q [ADD_LAT+1];

    assign O_req_rdy = gnt_c;
    assign acc_c     = |(I_req_vld & gnt_c);

    adder_share_arb_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .I_clk      (I_clk),
        .I_rst      (I_rst),
        .I_en       (I_en),
        .I_req      (I_req_vld),
        .I_acc      (acc_c),
        .O_gnt_c    (gnt_c),
        .O_gnt_id_c (gnt_id_c)
    );

    // One-hot AND-OR operand mux driven by the grant.
    always_comb begin
        a_sel_c = '0;
        b_sel_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt_c[k]) begin
                a_sel_c = a_sel_c | I_req_a[k*DW +: DW];
                b_sel_c = b_sel_c | I_req_b[k*DW +: DW];
            end
        end
    end

    always_comb begin
        tag_any_c = 1'b0;
        for (int unsigned i = 0; i <= ADD_LAT; i++) begin
            tag_any_c = tag_any_c | tag_q[i].vld;
        end
    end

    // Stage 0 is loaded in lockstep with O_add_*, so stage ADD_LAT lines up with I_sum.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_add_a     <= '0;
            O_add_b     <= '0;
            O_add_vld   <= 1'b0;
            O_res_vld   <= 1'b0;
            O_res_id    <= '0;
            O_res_sum   <= '0;
            O_busy      <= 1'b0;
            O_issue_cnt <= '0;
            for (int unsigned i = 0; i <= ADD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            O_add_vld <= acc_c;
            if (acc_c) begin
                O_add_a     <= a_sel_c;
                O_add_b     <= b_sel_c;
                O_issue_cnt <= O_issue_cnt + CNT_W'(1);
            end
            tag_q[0] <= '{vld: acc_c, id: MAX_IDW'(gnt_id_c)};
            for (int unsigned i = 1; i <= ADD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            O_res_vld <= tag_q[ADD_LAT].vld;
            if (tag_q[ADD_LAT].vld) begin
                O_res_id  <= IDW'(tag_q[ADD_LAT].id);
                O_res_sum <= I_sum;
            end
            O_busy <= acc_c | tag_any_c;
        end
    end

endmodule
